data_launch: RTL and testbench

Source-domain launcher for the multi-clock data path. It accepts words from local logic over a valid/ready handshake and drives a held multi-bit bus plus a level enable toward the destination-domain synchronizer. It keeps the bus stable for the entire transfer using a four-phase request/acknowledge handshake, where the acknowledge is the destination's synchronized copy of the enable. One word can be buffered while a transfer is in flight.

---
 rtl/data_launch_if.sv | 53 +++++
 rtl/data_launch.sv | 159 +++++++++++++++
 tb/tb_data_launch.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_launch_if.sv
// -----------------------------------------------------------------------------
// data_launch_if
//   Bundles the local-side valid/ready word handshake and the held bus /
//   level-enable pair toward the destination-domain synchronizer.
//
//   Signals
//     in_data     word offered by local logic
//     in_valid    in_data valid
//     in_ready    launcher can accept a word this cycle
//     ack         destination's synchronized copy of bus_enable (async here)
//     unsync_bus  held data toward the destination synchronizer
//     bus_enable  level request, high while a word is presented
//     done        one-cycle pulse per acknowledged word
//     busy        launcher not idle or holding a pending word
//
//   Modports
//     master  the launcher itself
//     slave   the environment around it (local logic + destination side)
// -----------------------------------------------------------------------------
interface data_launch_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ack;
  logic [WIDTH-1:0] unsync_bus;
  logic             bus_enable;
  logic             done;
  logic             busy;

  modport master (
    input  in_data,
    input  in_valid,
    input  ack,
    output in_ready,
    output unsync_bus,
    output bus_enable,
    output done,
    output busy
  );

  modport slave (
    output in_data,
    output in_valid,
    output ack,
    input  in_ready,
    input  unsync_bus,
    input  bus_enable,
    input  done,
    input  busy
  );
endinterface

// File: rtl/data_launch.sv
// -----------------------------------------------------------------------------
// data_launch
//   Source-domain side of a four-phase bus-hold crossing. Words arrive over a
//   valid/ready handshake, are placed on a held bus and announced with a level
//   enable. The destination returns its synchronized copy of the enable as ack;
//   the bus never changes while the enable is high. One word can wait in a
//   pending buffer while a transfer is in flight.
//
//   Parameters
//     STAGES  depth of the ack synchronizer (>= 2)
//     WIDTH   data bus width
//
//   Ports
//     DataLaunch_CLK  source-domain clock
//     DataLaunch_RST  synchronous, active-high reset
//     dl              data_launch_if.master (handshake, bus, enable, status)
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no word on the bus; enable low; waiting for a word and ack_s=0
//   REQ     | word held on the bus, enable high; waiting for ack_s=1
//   RELEASE | enable low after ack; waiting for ack_s=0 before next launch
// -----------------------------------------------------------------------------
module data_launch #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 8
) (
  input  logic          DataLaunch_CLK,
  input  logic          DataLaunch_RST,
  data_launch_if.master dl
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } stateT;

  stateT            state;
  stateT            nextState;

  logic [STAGES-1:0] ackSync;
  logic              ackS;

  logic [WIDTH-1:0] busReg;
  logic [WIDTH-1:0] pendingData;
  logic             pendingFull;
  logic             enableReg;
  logic             doneReg;

  logic             accept;
  logic             loadDirect;
  logic             loadPending;
  logic             writePending;
  logic             nextDone;
  logic             nextEnable;

  assign ackS = ackSync[STAGES-1];

  // Ready depends only on registered state, so the upstream handshake never
  // sees a combinational path from in_valid or ack.
  assign accept = dl.in_valid & ~pendingFull;

  always_comb begin
    nextState   = state;
    loadDirect  = 1'b0;
    loadPending = 1'b0;
    nextDone    = 1'b0;
    case (state)
      IDLE: begin
        // A high ack_s here is stale from an earlier transfer or a reset
        // taken mid-handshake; launching now would break the four-phase
        // sequence, so any word waits in pending instead.
        if (!ackS) begin
          if (pendingFull) begin
            loadPending = 1'b1;
            nextState   = REQ;
          end else if (accept) begin
            loadDirect = 1'b1;
            nextState  = REQ;
          end
        end
      end
      REQ: begin
        if (ackS) begin
          nextState = RELEASE;
          nextDone  = 1'b1;
        end
      end
      RELEASE: begin
        if (!ackS) begin
          if (pendingFull) begin
            loadPending = 1'b1;
            nextState   = REQ;
          end else begin
            nextState = IDLE;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Words not launched directly go to pending; accept and loadPending are
  // mutually exclusive because both depend on opposite values of pendingFull.
  assign writePending = accept & ~loadDirect;

  // Enable is registered from the next state so it falls on the same edge
  // that leaves REQ and rises on the same edge that loads the bus.
  assign nextEnable = (nextState == REQ);

  always_ff @(posedge DataLaunch_CLK) begin
    if (DataLaunch_RST) begin
      ackSync     <= '0;
      state       <= IDLE;
      busReg      <= '0;
      pendingData <= '0;
      pendingFull <= 1'b0;
      enableReg   <= 1'b0;
      doneReg     <= 1'b0;
    end else begin
      ackSync   <= {ackSync[STAGES-2:0], dl.ack};
      state     <= nextState;
      enableReg <= nextEnable;
      doneReg   <= nextDone;

      if (loadDirect) begin
        busReg <= dl.in_data;
      end else if (loadPending) begin
        busReg <= pendingData;
      end

      if (writePending) begin
        pendingData <= dl.in_data;
        pendingFull <= 1'b1;
      end else if (loadPending) begin
        pendingFull <= 1'b0;
      end
    end
  end

  assign dl.in_ready   = ~pendingFull;
  assign dl.unsync_bus = busReg;
  assign dl.bus_enable = enableReg;
  assign dl.done       = doneReg;
  assign dl.busy       = (state != IDLE) | pendingFull;

  // The bus may only be reloaded while the enable is low.
  always_ff @(posedge DataLaunch_CLK) begin
    if (!DataLaunch_RST && (loadDirect || loadPending)) begin
      assert (!enableReg);
    end
  end

  // A completion pulse is never followed directly by another one.
  assert property (@(posedge DataLaunch_CLK) disable iff (DataLaunch_RST)
                   doneReg |=> !doneReg);

endmodule

// File: tb/tb_data_launch.sv
module tb_data_launch;

  logic DataLaunch_CLK = 1'b0;
  logic DataLaunch_RST = 1'b1;

  always #5 DataLaunch_CLK = ~DataLaunch_CLK;

  data_launch_if #(.WIDTH(8)) dlIf ();

  data_launch #(
    .STAGES(2),
    .WIDTH (8)
  ) dut (
    .DataLaunch_CLK(DataLaunch_CLK),
    .DataLaunch_RST(DataLaunch_RST),
    .dl            (dlIf)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  logic [7:0] expQ[$];
  logic [7:0] obsQ[$];

  bit autoAck = 1'b0;
  int ackCnt  = 0;

  // Monitor: records launches and done pulses; all checking happens in the
  // main process.
  int         doneCount  = 0;
  int         doneDouble = 0;
  int         busHoldErr = 0;
  logic       prevEn     = 1'b0;
  logic       prevDone   = 1'b0;
  logic [7:0] prevBus    = 8'h00;

  always @(negedge DataLaunch_CLK) begin
    if (!DataLaunch_RST) begin
      if (dlIf.done) begin
        doneCount++;
        if (prevDone) doneDouble++;
      end
      if (dlIf.bus_enable && !prevEn) obsQ.push_back(dlIf.unsync_bus);
      if (dlIf.bus_enable && prevEn && (dlIf.unsync_bus !== prevBus)) busHoldErr++;
    end
    prevEn   = dlIf.bus_enable;
    prevDone = dlIf.done;
    prevBus  = dlIf.unsync_bus;
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Destination model: raise ack 4 cycles after enable rises, drop it 4
  // cycles after enable falls.
  task automatic ackStep();
    if (autoAck) begin
      if (dlIf.bus_enable && !dlIf.ack) begin
        ackCnt++;
        if (ackCnt >= 4) begin
          dlIf.ack = 1'b1;
          ackCnt   = 0;
        end
      end else if (!dlIf.bus_enable && dlIf.ack) begin
        ackCnt++;
        if (ackCnt >= 4) begin
          dlIf.ack = 1'b0;
          ackCnt   = 0;
        end
      end else begin
        ackCnt = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge DataLaunch_CLK);
    ackStep();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offer one word; returns on the negedge after the accepting edge.
  task automatic offer(input logic [7:0] d, input int budget, input string tag);
    dlIf.in_data  = d;
    dlIf.in_valid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (dlIf.in_ready) begin
        expQ.push_back(d);
        tick();
        dlIf.in_valid = 1'b0;
        return;
      end
      tick();
    end
    dlIf.in_valid = 1'b0;
    checkVal({tag, "_accept"}, {31'd0, dlIf.in_ready}, 32'd1);
  endtask

  task automatic waitDone(input int target, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (doneCount >= target) break;
      tick();
    end
    checkVal(tag, doneCount, target);
  endtask

  task automatic drain(input string tag);
    logic [7:0] o;
    while (obsQ.size() > 0) begin
      o = obsQ.pop_front();
      if (expQ.size() > 0) checkVal({tag, "_launch"}, {24'd0, o}, {24'd0, expQ.pop_front()});
      else checkVal({tag, "_unexpected_launch"}, {24'd0, o}, 32'hFFFF_FFFF);
    end
  endtask

  int d0;

  initial begin
    dlIf.in_data  = 8'h00;
    dlIf.in_valid = 1'b0;
    dlIf.ack      = 1'b0;

    // Reset values
    ticks(3);
    checkVal("rst_bus",   {24'd0, dlIf.unsync_bus}, 32'h00);
    checkVal("rst_en",    {31'd0, dlIf.bus_enable}, 32'd0);
    checkVal("rst_done",  {31'd0, dlIf.done},       32'd0);
    checkVal("rst_busy",  {31'd0, dlIf.busy},       32'd0);
    checkVal("rst_ready", {31'd0, dlIf.in_ready},   32'd1);
    DataLaunch_RST = 1'b0;
    tick();

    // Single word, manual ack with exact latencies
    offer(8'hA5, 10, "sw");
    checkVal("sw_en",   {31'd0, dlIf.bus_enable}, 32'd1);
    checkVal("sw_bus",  {24'd0, dlIf.unsync_bus}, 32'hA5);
    checkVal("sw_busy", {31'd0, dlIf.busy},       32'd1);
    ticks(3);
    dlIf.ack = 1'b1;
    tick();
    checkVal("sw_done_early1", {31'd0, dlIf.done}, 32'd0);
    tick();
    checkVal("sw_done_early2", {31'd0, dlIf.done}, 32'd0);
    checkVal("sw_en_held",     {31'd0, dlIf.bus_enable}, 32'd1);
    tick();
    checkVal("sw_done",     {31'd0, dlIf.done},       32'd1);
    checkVal("sw_en_fall",  {31'd0, dlIf.bus_enable}, 32'd0);
    tick();
    checkVal("sw_done_once", {31'd0, dlIf.done},      32'd0);
    ticks(3);
    dlIf.ack = 1'b0;
    tick();
    checkVal("sw_busy_rel1", {31'd0, dlIf.busy}, 32'd1);
    tick();
    checkVal("sw_busy_rel2", {31'd0, dlIf.busy}, 32'd1);
    tick();
    checkVal("sw_idle",      {31'd0, dlIf.busy},     32'd0);
    checkVal("sw_ready",     {31'd0, dlIf.in_ready}, 32'd1);
    checkVal("sw_bus_keep",  {24'd0, dlIf.unsync_bus}, 32'hA5);
    drain("sw");

    // Buffered word and ready stall, automatic destination
    autoAck = 1'b1;
    ackCnt  = 0;
    d0      = doneCount;
    offer(8'h11, 10, "buf11");
    offer(8'h22, 10, "buf22");
    checkVal("buf_ready_low", {31'd0, dlIf.in_ready},   32'd0);
    checkVal("buf_bus_hold",  {24'd0, dlIf.unsync_bus}, 32'h11);
    checkVal("buf_en",        {31'd0, dlIf.bus_enable}, 32'd1);
    dlIf.in_data  = 8'h33;
    dlIf.in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (dlIf.in_ready) break;
      tick();
    end
    checkVal("stall_ready", {31'd0, dlIf.in_ready},   32'd1);
    checkVal("stall_bus",   {24'd0, dlIf.unsync_bus}, 32'h22);
    checkVal("stall_en",    {31'd0, dlIf.bus_enable}, 32'd1);
    if (dlIf.in_ready) expQ.push_back(8'h33);
    tick();
    dlIf.in_valid = 1'b0;
    checkVal("stall_pend33", {31'd0, dlIf.in_ready}, 32'd0);
    waitDone(d0 + 3, 300, "order_done_cnt");
    ticks(12);
    checkVal("order_done_total", doneCount, d0 + 3);
    checkVal("order_idle",       {31'd0, dlIf.busy}, 32'd0);
    drain("order");

    // Reset while in REQ with pending full
    offer(8'h44, 10, "rst44");
    offer(8'h55, 10, "rst55");
    checkVal("rst_mid_pend", {31'd0, dlIf.in_ready}, 32'd0);
    DataLaunch_RST = 1'b1;
    tick();
    checkVal("rstm_en",    {31'd0, dlIf.bus_enable}, 32'd0);
    checkVal("rstm_bus",   {24'd0, dlIf.unsync_bus}, 32'h00);
    checkVal("rstm_ready", {31'd0, dlIf.in_ready},   32'd1);
    checkVal("rstm_done",  {31'd0, dlIf.done},       32'd0);
    DataLaunch_RST = 1'b0;
    drain("rstm_pre");
    expQ.delete();
    d0 = doneCount;
    ticks(20);
    checkVal("rstm_no_done",   doneCount, d0);
    checkVal("rstm_no_launch", obsQ.size(), 0);
    checkVal("rstm_en_low",    {31'd0, dlIf.bus_enable}, 32'd0);

    // Stale ack held across reset release
    autoAck  = 1'b0;
    dlIf.ack = 1'b1;
    DataLaunch_RST = 1'b1;
    ticks(2);
    DataLaunch_RST = 1'b0;
    ticks(3);
    offer(8'h5A, 10, "stale");
    checkVal("stale_en",   {31'd0, dlIf.bus_enable}, 32'd0);
    checkVal("stale_pend", {31'd0, dlIf.in_ready},   32'd0);
    ticks(3);
    checkVal("stale_hold", {31'd0, dlIf.bus_enable}, 32'd0);
    dlIf.ack = 1'b0;
    tick();
    checkVal("stale_wait1", {31'd0, dlIf.bus_enable}, 32'd0);
    tick();
    checkVal("stale_wait2", {31'd0, dlIf.bus_enable}, 32'd0);
    tick();
    checkVal("stale_launch", {31'd0, dlIf.bus_enable}, 32'd1);
    checkVal("stale_bus",    {24'd0, dlIf.unsync_bus}, 32'h5A);
    d0 = doneCount;
    ticks(2);
    dlIf.ack = 1'b1;
    waitDone(d0 + 1, 20, "stale_done");
    ticks(2);
    dlIf.ack = 1'b0;
    ticks(5);
    drain("stale");

    // Ack glitch during RELEASE
    d0 = doneCount;
    offer(8'h66, 10, "glitch");
    ticks(2);
    dlIf.ack = 1'b1;
    waitDone(d0 + 1, 20, "glitch_done");
    dlIf.ack = 1'b0;
    tick();
    dlIf.ack = 1'b1;
    ticks(6);
    checkVal("glitch_no_relaunch", {31'd0, dlIf.bus_enable}, 32'd0);
    dlIf.ack = 1'b0;
    ticks(6);
    checkVal("glitch_one_done", doneCount, d0 + 1);
    checkVal("glitch_idle",     {31'd0, dlIf.busy}, 32'd0);

    tick();
    drain("final");
    checkVal("exp_leftover", expQ.size(), 0);
    checkVal("bus_hold_err", busHoldErr,  0);
    checkVal("done_double",  doneDouble,  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
